router_sync_n: RTL and testbench

- Parametrised N-channel synchronizer between the router FSM, the register block and the N output FIFOs.
- Latches the destination address from the header and steers write enables.
- Multiplexes the selected FIFO full flag.
- Generates per-channel valid-out and a one-cycle soft-reset pulse when a channel's reader stalls too long.
- Successor to the fixed 3-channel synchronizer; adds an invalid-address flag, pulsed soft reset and configurable timeout.

---
 rtl/router_pkg.sv | 22 ++
 rtl/router_sync_timer.sv | 67 ++++++
 rtl/router_sync_n.sv | 78 +++++++
 tb/tb_router_sync_n.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants and helpers for the N-channel router synchronizer.
package router_pkg;

    localparam int ROUTER_NUM_CH  = 3;
    localparam int ROUTER_ADDR_W  = 2;
    localparam int ROUTER_TIMEOUT = 30;
    localparam int ROUTER_MAX_CH  = 16;

    // Sized for the largest legal channel count; callers keep the low NUM_CH bits.
    function automatic logic [ROUTER_MAX_CH-1:0] onehot_dec(input logic [31:0] addr,
                                                            input logic        en);
        logic [ROUTER_MAX_CH-1:0] v;
        v = '0;
        for (int i = 0; i < ROUTER_MAX_CH; i++) begin
            if (en && (addr == 32'(i))) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/router_sync_timer.sv
// One channel's reader-stall counter producing a single-cycle soft-reset pulse.
// Optional sticky timeout status under ROUTER_SYNC_TIMEOUT_STATUS_EN.
module router_sync_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = ROUTER_TIMEOUT,
    parameter int TMR_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic vld,
    input  logic rd,
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
    input  logic clr_status,
    output logic timeout_sticky,
`endif
    output logic soft_reset
);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             pulse_q, pulse_d;
    logic             stall;

    assign stall = vld & ~rd;

    // Expiry restarts the count at zero, so a persistent stall pulses every TIMEOUT cycles.
    always_comb begin
        tmr_d   = '0;
        pulse_d = 1'b0;
        if (stall) begin
            if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                pulse_d = 1'b1;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            tmr_q   <= tmr_d;
            pulse_q <= pulse_d;
        end
    end

    assign soft_reset = pulse_q;

`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
    logic sticky_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else if (pulse_d) begin
            sticky_q <= 1'b1;
        end else if (clr_status) begin
            sticky_q <= 1'b0;
        end
    end

    assign timeout_sticky = sticky_q;
`endif

endmodule

// File: rtl/router_sync_n.sv
// N-channel synchronizer: header address latch, write-enable steering, full mux,
// valid-out and per-channel stall timeouts. Optional: ROUTER_SYNC_TIMEOUT_STATUS_EN.
module router_sync_n
    import router_pkg::*;
#(
    parameter int NUM_CH  = ROUTER_NUM_CH,
    parameter int ADDR_W  = ROUTER_ADDR_W,
    parameter int TIMEOUT = ROUTER_TIMEOUT,
    parameter int TMR_W   = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              detect_addr,
    input  logic              write_enb_reg,
    input  logic [ADDR_W-1:0] data_in,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] read_enb,
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
    input  logic              clr_status,
    output logic [NUM_CH-1:0] timeout_sticky,
`endif
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic              addr_err,
    output logic [NUM_CH-1:0] soft_reset
);

    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [ROUTER_MAX_CH-1:0] dec_all;
    logic                     unused_dec;

    assign addr_d = detect_addr ? data_in : addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_err   = (32'(addr_q) >= 32'(NUM_CH));
    assign dec_all    = onehot_dec(32'(addr_q), write_enb_reg & ~addr_err);
    assign write_enb  = dec_all[NUM_CH-1:0];
    assign unused_dec = ^dec_all;

    // Unmapped address reads as full so the FSM stalls instead of writing nowhere.
    always_comb begin
        fifo_full = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (32'(addr_q) == 32'(i)) begin
                fifo_full = full[i];
            end
        end
    end

    assign vld_out = ~empty;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        router_sync_timer #(
            .TIMEOUT (TIMEOUT),
            .TMR_W   (TMR_W)
        ) u_timer (
            .clk            (clk),
            .reset          (reset),
            .vld            (vld_out[g]),
            .rd             (read_enb[g]),
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
            .clr_status     (clr_status),
            .timeout_sticky (timeout_sticky[g]),
`endif
            .soft_reset     (soft_reset[g])
        );
    end

endmodule

// File: tb/tb_router_sync_n.sv
// Scoreboard bench for router_sync_n: default 3-channel instance plus a 4-channel, TIMEOUT=5 instance.
module tb_router_sync_n;

    logic       clk = 1'b0;
    logic       reset;
    logic       detect_addr, write_enb_reg;
    logic [1:0] data_in;
    logic [2:0] empty, full, read_enb;
    logic [2:0] vld_out, write_enb, soft_reset;
    logic       fifo_full, addr_err;

    logic       b_reset;
    logic       b_detect, b_wer;
    logic [1:0] b_data;
    logic [3:0] b_empty, b_full, b_read;
    logic [3:0] b_vld, b_we, b_sr;
    logic       b_ff, b_ae;

`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
    logic       clr_status = 1'b0;
    logic [2:0] timeout_sticky;
    logic [3:0] b_sticky;
`endif

    int vectors = 0;
    int errors  = 0;

    logic [10:0] exp_q[$];
    logic [13:0] exp_b_q[$];

    always #5 clk = ~clk;

    router_sync_n u_dut (
        .clk            (clk),
        .reset          (reset),
        .detect_addr    (detect_addr),
        .write_enb_reg  (write_enb_reg),
        .data_in        (data_in),
        .empty          (empty),
        .full           (full),
        .read_enb       (read_enb),
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
        .clr_status     (clr_status),
        .timeout_sticky (timeout_sticky),
`endif
        .vld_out        (vld_out),
        .write_enb      (write_enb),
        .fifo_full      (fifo_full),
        .addr_err       (addr_err),
        .soft_reset     (soft_reset)
    );

    router_sync_n #(.NUM_CH(4), .ADDR_W(2), .TIMEOUT(5)) u_dut4 (
        .clk            (clk),
        .reset          (b_reset),
        .detect_addr    (b_detect),
        .write_enb_reg  (b_wer),
        .data_in        (b_data),
        .empty          (b_empty),
        .full           (b_full),
        .read_enb       (b_read),
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
        .clr_status     (clr_status),
        .timeout_sticky (b_sticky),
`endif
        .vld_out        (b_vld),
        .write_enb      (b_we),
        .fifo_full      (b_ff),
        .addr_err       (b_ae),
        .soft_reset     (b_sr)
    );

    logic [10:0] obs_a;
    logic [13:0] obs_b;
    assign obs_a = {write_enb, fifo_full, addr_err, soft_reset, vld_out};
    assign obs_b = {b_we, b_ff, b_ae, b_sr, b_vld};

    function automatic logic [10:0] mk_a(logic [2:0] we, logic ff, logic ae,
                                         logic [2:0] sr, logic [2:0] vld);
        return {we, ff, ae, sr, vld};
    endfunction

    function automatic logic [13:0] mk_b(logic [3:0] we, logic ff, logic ae,
                                         logic [3:0] sr, logic [3:0] vld);
        return {we, ff, ae, sr, vld};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        reset = 1'b1; full = 3'b001; empty = 3'b111;
        next_cycle();
        reset = 1'b0;
        exp_q.push_back(mk_a(3'b000, 1'b1, 1'b0, 3'b000, 3'b000));
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (obs_a !== e) begin
            errors++;
            $display("FAIL reset: got %b want %b", obs_a, e);
        end
        next_cycle();
    endtask

    task automatic test_steering();
        logic [10:0] e;
        for (int n = 0; n < 6; n++) begin
            detect_addr   = (n == 0);
            data_in       = 2'd2;
            write_enb_reg = (n >= 1 && n <= 4);
            full          = (n == 5) ? 3'b000 : 3'b100;
            if (n == 0)      exp_q.push_back(mk_a(3'b000, 1'b0, 1'b0, 3'b000, 3'b000));
            else if (n <= 4) exp_q.push_back(mk_a(3'b100, 1'b1, 1'b0, 3'b000, 3'b000));
            else             exp_q.push_back(mk_a(3'b000, 1'b0, 1'b0, 3'b000, 3'b000));
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL steering cyc %0d: got %b want %b", n, obs_a, e);
            end
            next_cycle();
        end
        detect_addr = 1'b0; write_enb_reg = 1'b0;
    endtask

    task automatic test_same_cycle_header();
        logic [10:0] e;
        full = 3'b000;
        for (int n = 0; n < 4; n++) begin
            detect_addr   = (n <= 1);
            data_in       = (n == 0) ? 2'd0 : 2'd1;
            write_enb_reg = (n == 1 || n == 2);
            case (n)
                1:       exp_q.push_back(mk_a(3'b001, 1'b0, 1'b0, 3'b000, 3'b000));
                2:       exp_q.push_back(mk_a(3'b010, 1'b0, 1'b0, 3'b000, 3'b000));
                default: exp_q.push_back(mk_a(3'b000, 1'b0, 1'b0, 3'b000, 3'b000));
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL same_cycle_hdr cyc %0d: got %b want %b", n, obs_a, e);
            end
            next_cycle();
        end
        detect_addr = 1'b0; write_enb_reg = 1'b0;
    endtask

    task automatic test_invalid_addr();
        logic [10:0] e;
        full = 3'b000;
        for (int n = 0; n < 5; n++) begin
            detect_addr   = (n == 0 || n == 3);
            data_in       = (n == 0) ? 2'd3 : 2'd0;
            write_enb_reg = (n == 1 || n == 2);
            if (n >= 1 && n <= 3) exp_q.push_back(mk_a(3'b000, 1'b1, 1'b1, 3'b000, 3'b000));
            else                  exp_q.push_back(mk_a(3'b000, 1'b0, 1'b0, 3'b000, 3'b000));
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL invalid_addr cyc %0d: got %b want %b", n, obs_a, e);
            end
            next_cycle();
        end
        detect_addr = 1'b0; write_enb_reg = 1'b0;
    endtask

    task automatic test_timeout_pulse();
        logic [10:0] e;
        empty = 3'b101; read_enb = 3'b000;
        for (int n = 1; n <= 70; n++) begin
            exp_q.push_back(mk_a(3'b000, 1'b0, 1'b0,
                                 (n == 31 || n == 61) ? 3'b010 : 3'b000, 3'b010));
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL timeout_pulse cyc %0d: got %b want %b", n, obs_a, e);
            end
            next_cycle();
        end
        empty = 3'b111;
        next_cycle();
    endtask

    task automatic test_read_rescue();
        logic [10:0] e;
        empty = 3'b110;
        for (int n = 1; n <= 61; n++) begin
            read_enb = (n == 30 || n == 60) ? 3'b001 : 3'b000;
            exp_q.push_back(mk_a(3'b000, 1'b0, 1'b0, 3'b000, 3'b001));
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL read_rescue cyc %0d: got %b want %b", n, obs_a, e);
            end
            next_cycle();
        end
        empty = 3'b111; read_enb = 3'b000;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        logic [10:0] e;
        empty = 3'b011;
        for (int n = 1; n <= 55; n++) begin
            reset = (n == 20);
            exp_q.push_back(mk_a(3'b000, 1'b0, 1'b0,
                                 (n == 51) ? 3'b100 : 3'b000, 3'b100));
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL reset_mid cyc %0d: got %b want %b", n, obs_a, e);
            end
            next_cycle();
        end
        reset = 1'b0; empty = 3'b111;
        next_cycle();
    endtask

    task automatic test_params();
        logic [13:0] e;
        b_reset = 1'b0; b_full = 4'b1000; b_read = 4'b0000;
        for (int n = 0; n <= 8; n++) begin
            b_detect = (n == 0);
            b_data   = 2'd3;
            b_wer    = (n == 1);
            b_empty  = (n == 0) ? 4'b1111 : 4'b0111;
            if (n == 0)      exp_b_q.push_back(mk_b(4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000));
            else if (n == 1) exp_b_q.push_back(mk_b(4'b1000, 1'b1, 1'b0, 4'b0000, 4'b1000));
            else             exp_b_q.push_back(mk_b(4'b0000, 1'b1, 1'b0,
                                                    (n == 6) ? 4'b1000 : 4'b0000, 4'b1000));
            @(negedge clk);
            e = exp_b_q.pop_front();
            vectors++;
            if (obs_b !== e) begin
                errors++;
                $display("FAIL params4 cyc %0d: got %b want %b", n, obs_b, e);
            end
            next_cycle();
        end
        b_detect = 1'b0; b_wer = 1'b0; b_empty = 4'b1111;
    endtask

    initial begin
        reset = 1'b1; detect_addr = 1'b0; write_enb_reg = 1'b0; data_in = 2'd0;
        empty = 3'b111; full = 3'b000; read_enb = 3'b000;
        b_reset = 1'b1; b_detect = 1'b0; b_wer = 1'b0; b_data = 2'd0;
        b_empty = 4'b1111; b_full = 4'b0000; b_read = 4'b0000;
        next_cycle();

        test_reset();
        test_steering();
        test_same_cycle_header();
        test_invalid_addr();
        test_timeout_pulse();
        test_read_rescue();
        test_reset_mid();
        test_params();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
